// File: rtl/micron_pkg.sv
// Shared types and constants for the Micron cellular-RAM emulator.
// The FSM state enum, the captured write beat, and the BCR defaults live here.
package micron_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] BCR_DEFAULT = 16'h9D1F;
    localparam logic [1:0]        BCR_SEL     = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_ACTIVE,
        CR_WRITE
    } state_e;

    // One captured write beat; the byte enables stay active-low as on the pins.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ub_n;
        logic              lb_n;
    } wr_cap_t;

    function automatic logic [1:0] byte_en(input wr_cap_t cap);
        return {~cap.ub_n, ~cap.lb_n};
    endfunction

endpackage

// File: rtl/micron_emu_mem.sv
// Single-port word array with per-byte write enables and combinational read.
// Contents have no reset so they survive a controller reset.
module micron_emu_mem
    import micron_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8,
    parameter int AW           = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [1:0]        be_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [NUM_ELEMENTS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
            if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/micron_psram_emulator.sv
// Behavioural emulator of a Micron async/page PSRAM as seen by a synchronous
// controller: latched address, fixed read latency, byte writes and BCR writes.
module micron_psram_emulator
    import micron_pkg::*;
#(
    parameter int NUM_ELEMENTS = 8,
    parameter int READ_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              ce_L,
    input  logic              adv_L,
    input  logic              oe_L,
    input  logic              we_L,
    input  logic              ub_L,
    input  logic              lb_L,
    input  logic              cre,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              mem_wait,
    output logic [DATA_W-1:0] bcr
);

    localparam int AW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [CW-1:0]     LAT_LOAD   = CW'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_ELEMENTS);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    wr_cap_t           cap_q,   cap_d;
    logic [DATA_W-1:0] dout_q,  dout_d;
    logic              doe_q,   doe_d;
    logic              wait_q,  wait_d;
    logic [DATA_W-1:0] bcr_q,   bcr_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_word;

    assign in_range = (addr_q < ADDR_LIMIT);
    assign rd_word  = in_range ? mem_rdata : '0;

    micron_emu_mem #(
        .NUM_ELEMENTS (NUM_ELEMENTS),
        .AW           (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we & ~rst),
        .be_i    (byte_en(cap_q)),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (cap_q.data),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        doe_d   = 1'b0;
        wait_d  = 1'b0;
        bcr_d   = bcr_q;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!ce_L && !adv_L) begin
                    addr_d = addr;
                    // Write wins over a simultaneous output enable.
                    if (!we_L) begin
                        cap_d   = '{data: data_in, ub_n: ub_L, lb_n: lb_L};
                        state_d = cre ? CR_WRITE : WR_ACTIVE;
                    end else if (!oe_L) begin
                        state_d = RD_WAIT;
                        cnt_d   = LAT_LOAD;
                        wait_d  = 1'b1;
                    end
                end
            end

            RD_WAIT: begin
                if (ce_L || oe_L) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RD_DRIVE;
                    doe_d   = 1'b1;
                    dout_d  = rd_word;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    wait_d = 1'b1;
                end
            end

            RD_DRIVE: begin
                if (ce_L || oe_L) begin
                    state_d = IDLE;
                end else if (!adv_L) begin
                    addr_d  = addr;
                    state_d = RD_WAIT;
                    cnt_d   = LAT_LOAD;
                    wait_d  = 1'b1;
                end else begin
                    doe_d  = 1'b1;
                    dout_d = rd_word;
                end
            end

            WR_ACTIVE: begin
                // The commit uses the beat captured before the closing edge.
                if (we_L || ce_L) begin
                    mem_we  = in_range;
                    state_d = IDLE;
                end else begin
                    cap_d = '{data: data_in, ub_n: ub_L, lb_n: lb_L};
                end
            end

            CR_WRITE: begin
                if (we_L || ce_L) begin
                    if (addr_q[19:18] == BCR_SEL) bcr_d = addr_q[15:0];
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            wait_q  <= 1'b0;
            bcr_q   <= BCR_DEFAULT;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            wait_q  <= wait_d;
            bcr_q   <= bcr_d;
        end
    end

    assign data_out = dout_q;
    assign data_oe  = doe_q;
    assign mem_wait = wait_q;
    assign bcr      = bcr_q;

endmodule

// File: tb/tb_micron_psram_emulator.sv
// Directed plus randomized bench for micron_psram_emulator with a word-array
// reference model kept in the bench.
module tb_micron_psram_emulator;

    localparam int NE  = 8;
    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic [22:0] addr;
    logic        ce_L, adv_L, oe_L, we_L, ub_L, lb_L, cre;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic        mem_wait;
    logic [15:0] bcr;

    int checks;
    int failures;

    logic [15:0] ref_mem [NE];
    logic [15:0] ref_bcr;

    micron_psram_emulator #(
        .NUM_ELEMENTS (NE),
        .READ_LAT     (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .ce_L     (ce_L),
        .adv_L    (adv_L),
        .oe_L     (oe_L),
        .we_L     (we_L),
        .ub_L     (ub_L),
        .lb_L     (lb_L),
        .cre      (cre),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .mem_wait (mem_wait),
        .bcr      (bcr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [22:0] a);
        return (a < 23'(NE)) ? ref_mem[a[2:0]] : 16'h0000;
    endfunction

    task automatic model_write(input logic [22:0] a, input logic [15:0] d,
                               input logic ub, input logic lb);
        if (a < 23'(NE)) begin
            if (!lb) ref_mem[a[2:0]][7:0]  = d[7:0];
            if (!ub) ref_mem[a[2:0]][15:8] = d[15:8];
        end
    endtask

    // we_L held low for ncyc samples; data_in is noise except on the last one.
    task automatic do_write(input logic [22:0] a, input logic [15:0] d, input logic ub,
                            input logic lb, input int ncyc, input bit end_by_ce);
        @(negedge clk);
        addr = a; ce_L = 0; adv_L = 0; we_L = 0; oe_L = 1; cre = 0;
        ub_L = ub; lb_L = lb;
        data_in = (ncyc == 1) ? d : 16'($urandom);
        @(posedge clk);
        for (int i = 2; i <= ncyc; i++) begin
            @(negedge clk);
            adv_L = 1; addr = 23'($urandom);
            data_in = (i == ncyc) ? d : 16'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        adv_L = 1; addr = 23'($urandom); data_in = 16'($urandom);
        if (end_by_ce) ce_L = 1; else we_L = 1;
        @(posedge clk);
        @(negedge clk);
        ce_L = 1; we_L = 1;
        model_write(a, d, ub, lb);
    endtask

    task automatic do_cr(input logic [22:0] a, input bit end_by_ce);
        @(negedge clk);
        addr = a; ce_L = 0; adv_L = 0; we_L = 0; oe_L = 1; cre = 1;
        @(posedge clk);
        @(negedge clk);
        adv_L = 1; cre = 0; addr = 23'($urandom);
        @(posedge clk);
        @(negedge clk);
        if (end_by_ce) ce_L = 1; else we_L = 1;
        @(posedge clk);
        @(negedge clk);
        ce_L = 1; we_L = 1;
        if (a[19:18] == 2'b10) ref_bcr = a[15:0];
        chk16("cr_bcr", bcr, ref_bcr);
    endtask

    task automatic start_read(input logic [22:0] a);
        @(negedge clk);
        addr = a; ce_L = 0; adv_L = 0; oe_L = 0; we_L = 1; cre = 0;
        @(posedge clk);
    endtask

    // Called just after the start edge; returns at a negedge with data driven.
    task automatic check_latency(input logic [15:0] exp);
        @(negedge clk);
        adv_L = 1; addr = 23'($urandom);
        chk1("lat_wait", mem_wait, 1'b1);
        chk1("lat_oe", data_oe, 1'b0);
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk1("lat_wait", mem_wait, 1'b1);
            chk1("lat_oe", data_oe, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        chk1("drv_oe", data_oe, 1'b1);
        chk1("drv_wait", mem_wait, 1'b0);
        chk16("drv_data", data_out, exp);
        @(posedge clk);
        @(negedge clk);
        chk1("hold_oe", data_oe, 1'b1);
        chk16("hold_data", data_out, exp);
    endtask

    task automatic end_read(input int mode);
        if (mode == 0) oe_L = 1;
        else if (mode == 1) ce_L = 1;
        else begin ce_L = 1; oe_L = 1; end
        @(posedge clk);
        @(negedge clk);
        chk1("end_oe", data_oe, 1'b0);
        chk1("end_wait", mem_wait, 1'b0);
        ce_L = 1; oe_L = 1;
    endtask

    task automatic do_read(input logic [22:0] a, input logic [15:0] exp, input int mode);
        start_read(a);
        check_latency(exp);
        end_read(mode);
    endtask

    initial begin
        logic [22:0] ra;
        logic [15:0] rd;
        checks = 0; failures = 0;
        rst = 1; addr = '0; ce_L = 1; adv_L = 1; oe_L = 1; we_L = 1;
        ub_L = 1; lb_L = 1; cre = 0; data_in = '0;
        ref_bcr = 16'h9D1F;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_oe", data_oe, 1'b0);
        chk1("rst_wait", mem_wait, 1'b0);
        chk16("rst_dout", data_out, 16'h0000);
        chk16("rst_bcr", bcr, 16'h9D1F);
        rst = 0;

        for (int a = 0; a < NE; a++) do_write(23'(a), 16'($urandom), 1'b0, 1'b0, 1, 1'b0);
        for (int a = 0; a < NE; a++) do_read(23'(a), model_read(23'(a)), 2);

        do_write(23'd3, 16'hBEEF, 1'b0, 1'b0, 3, 1'b0);
        do_read(23'd3, 16'hBEEF, 0);

        do_write(23'd5, 16'h1234, 1'b0, 1'b0, 2, 1'b0);
        do_write(23'd5, 16'hAB00, 1'b0, 1'b1, 1, 1'b1);
        do_read(23'd5, 16'hAB34, 1);

        // Abort in the second RD_WAIT cycle.
        start_read(23'd2);
        @(negedge clk); adv_L = 1;
        @(posedge clk);
        @(negedge clk); oe_L = 1;
        @(posedge clk);
        @(negedge clk);
        chk1("abort_wait", mem_wait, 1'b0);
        chk1("abort_oe", data_oe, 1'b0);
        repeat (LAT) begin
            @(posedge clk);
            @(negedge clk);
            chk1("abort_quiet", data_oe, 1'b0);
        end
        ce_L = 1;
        do_read(23'd2, model_read(23'd2), 2);

        // Re-latch a new address while data is being driven.
        start_read(23'd3);
        check_latency(16'hBEEF);
        adv_L = 0; addr = 23'd5;
        @(posedge clk);
        check_latency(16'hAB34);
        end_read(2);

        do_cr(23'h08_1234, 1'b0);
        chk16("bcr_set", bcr, 16'h1234);
        do_cr(23'h04_5678, 1'b1);
        chk16("bcr_keep", bcr, 16'h1234);
        for (int a = 0; a < NE; a++) do_read(23'(a), model_read(23'(a)), 2);

        // Reset with we_L still low: the pending write must vanish.
        do_write(23'd1, 16'h5A5A, 1'b0, 1'b0, 1, 1'b0);
        @(negedge clk);
        addr = 23'd1; ce_L = 0; adv_L = 0; we_L = 0; ub_L = 0; lb_L = 0; data_in = 16'hFFFF;
        @(posedge clk);
        @(negedge clk); adv_L = 1;
        @(posedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk);
        @(negedge clk);
        ref_bcr = 16'h9D1F;
        chk1("rstw_oe", data_oe, 1'b0);
        chk1("rstw_wait", mem_wait, 1'b0);
        chk16("rstw_bcr", bcr, 16'h9D1F);
        chk16("rstw_dout", data_out, 16'h0000);
        rst = 0; ce_L = 1; we_L = 1;
        do_read(23'd1, 16'h5A5A, 2);

        // Reset during read latency.
        start_read(23'd3);
        @(negedge clk); adv_L = 1; rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0; ce_L = 1; oe_L = 1;
        chk1("rstr_wait", mem_wait, 1'b0);
        repeat (LAT) begin
            @(posedge clk);
            @(negedge clk);
            chk1("rstr_oe", data_oe, 1'b0);
        end

        do_read(23'd8, 16'h0000, 2);
        do_write(23'd8, 16'hDEAD, 1'b0, 1'b0, 2, 1'b0);
        do_read(23'd0, model_read(23'd0), 2);

        for (int n = 0; n < 40; n++) begin
            ra = 23'($urandom_range(0, NE + 1));
            case ($urandom_range(0, 2))
                0: begin
                    rd = 16'($urandom);
                    do_write(ra, rd, 1'($urandom), 1'($urandom),
                             $urandom_range(1, 3), 1'($urandom));
                end
                1: do_read(ra, model_read(ra), $urandom_range(0, 2));
                default: begin
                    ra = 23'($urandom);
                    if ($urandom_range(0, 1) == 1) ra[19:18] = 2'b10;
                    do_cr(ra, 1'($urandom));
                end
            endcase
        end
        for (int a = 0; a < NE; a++) do_read(23'(a), model_read(23'(a)), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
